// File: rtl/dual_issue_unit.sv
// dual_issue_unit: instruction queue + pair hazard check feeding a registered dual issue slot.
// Optional `ISSUE_STATS_EN adds Stat_Dual/Stat_Single issue counters.
module dual_issue_unit #(
    parameter int DEPTH = 4,
    parameter int IW    = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Flush,
    input  logic          In_Valid1,
    input  logic          In_Valid2,
    input  logic [IW-1:0] In_Instr1,
    input  logic [IW-1:0] In_Instr2,
    output logic          In_Ready,
    input  logic          Iss_Ready,
    output logic          Iss_Valid1,
    output logic          Iss_Valid2,
    output logic [IW-1:0] Iss_Instr1,
    output logic [IW-1:0] Iss_Instr2,
    output logic [4:0]    A11,
    output logic [4:0]    A21,
    output logic [4:0]    A12,
    output logic [4:0]    A22,
    output logic [4:0]    Iss_Dst1,
    output logic [4:0]    Iss_Dst2,
    output logic          Iss_WE1,
    output logic          Iss_WE2
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]   Stat_Dual,
    output logic [31:0]   Stat_Single
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FREE2_LIM = (PW+1)'(DEPTH - 2);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       we;
        logic       urt;
        logic       br;
        logic       mem;
    } dec_t;

    function automatic dec_t decode(input logic [IW-1:0] ins);
        dec_t d;
        logic [5:0] op;
        op    = ins[31:26];
        d.rs  = ins[25:21];
        d.rt  = ins[20:16];
        d.dst = 5'd0;
        d.we  = 1'b0;
        d.urt = 1'b0;
        d.br  = op inside {6'd2, 6'd3, 6'd4, 6'd5};
        d.mem = op inside {6'd35, 6'd43};
        if (op == 6'd0) begin
            d.dst = ins[15:11];
            d.we  = |ins[15:11];
            d.urt = 1'b1;
        end else if (op inside {6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35}) begin
            d.dst = ins[20:16];
            d.we  = |ins[20:16];
        end else if (op inside {6'd43, 6'd4, 6'd5}) begin
            d.urt = 1'b1;
        end else if (op == 6'd3) begin
            d.dst = 5'd31;
            d.we  = 1'b1;
        end
        return d;
    endfunction

    logic [IW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_rd, r_wr;
    logic [PW:0]   r_cnt;

    logic [IW-1:0] w_head, w_next, w_ia, w_ib;
    dec_t          w_da, w_db, w_a, w_b;
    logic          w_any, w_dual, w_raw, w_waw, w_enq, w_unused;
    logic [PW:0]   w_enq_n, w_deq_n;

    assign In_Ready = r_cnt <= FREE2_LIM;
    assign w_head   = r_mem[r_rd];
    assign w_next   = r_mem[r_rd + PW'(1)];
    assign w_da     = decode(w_head);
    assign w_db     = decode(w_next);
    assign w_unused = w_da.urt ^ w_db.br;

    // B reads rt only when its encoding actually sources it
    assign w_raw  = w_da.we & ((w_db.rs == w_da.dst) | (w_db.urt & (w_db.rt == w_da.dst)));
    assign w_waw  = w_da.we & w_db.we & (w_da.dst == w_db.dst);
    assign w_any  = r_cnt != '0;
    assign w_dual = (r_cnt >= (PW+1)'(2)) & ~w_da.br & ~w_raw & ~w_waw & ~(w_da.mem & w_db.mem);

    assign w_a  = w_any  ? w_da   : '0;
    assign w_b  = w_dual ? w_db   : '0;
    assign w_ia = w_any  ? w_head : '0;
    assign w_ib = w_dual ? w_next : '0;

    assign w_enq   = In_Valid1 & In_Ready;
    assign w_enq_n = w_enq ? (In_Valid2 ? (PW+1)'(2) : (PW+1)'(1)) : '0;
    assign w_deq_n = (Iss_Ready & w_any) ? (w_dual ? (PW+1)'(2) : (PW+1)'(1)) : '0;

    always_ff @(posedge Clk) begin
        if (w_enq) begin
            r_mem[r_wr] <= In_Instr1;
            if (In_Valid2)
                r_mem[r_wr + PW'(1)] <= In_Instr2;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
        end else if (Flush) begin
            r_cnt <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
        end else begin
            r_cnt <= r_cnt + w_enq_n - w_deq_n;
            r_rd  <= r_rd + w_deq_n[PW-1:0];
            r_wr  <= r_wr + w_enq_n[PW-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset || Flush) begin
            Iss_Valid1 <= 1'b0;
            Iss_Valid2 <= 1'b0;
            Iss_Instr1 <= '0;
            Iss_Instr2 <= '0;
            A11        <= '0;
            A21        <= '0;
            A12        <= '0;
            A22        <= '0;
            Iss_Dst1   <= '0;
            Iss_Dst2   <= '0;
            Iss_WE1    <= 1'b0;
            Iss_WE2    <= 1'b0;
        end else if (Iss_Ready) begin
            Iss_Valid1 <= w_any;
            Iss_Valid2 <= w_dual;
            Iss_Instr1 <= w_ia;
            Iss_Instr2 <= w_ib;
            A11        <= w_a.rs;
            A21        <= w_a.rt;
            A12        <= w_b.rs;
            A22        <= w_b.rt;
            Iss_Dst1   <= w_a.dst;
            Iss_Dst2   <= w_b.dst;
            Iss_WE1    <= w_a.we;
            Iss_WE2    <= w_b.we;
        end
    end

`ifdef ISSUE_STATS_EN
    // Survives Flush; only Reset clears the statistics
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Stat_Dual   <= '0;
            Stat_Single <= '0;
        end else if (!Flush && Iss_Ready && w_any) begin
            if (w_dual)
                Stat_Dual <= Stat_Dual + 32'd1;
            else
                Stat_Single <= Stat_Single + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dual_issue_unit.sv
// tb_dual_issue_unit: directed plan scenarios plus random traffic against a queue-based reference model.
module tb_dual_issue_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Flush = 1'b0;
    logic        In_Valid1 = 1'b0, In_Valid2 = 1'b0, Iss_Ready = 1'b0;
    logic [31:0] In_Instr1 = '0, In_Instr2 = '0;
    logic        In_Ready, Iss_Valid1, Iss_Valid2, Iss_WE1, Iss_WE2;
    logic [31:0] Iss_Instr1, Iss_Instr2;
    logic [4:0]  A11, A21, A12, A22, Iss_Dst1, Iss_Dst2;
`ifdef ISSUE_STATS_EN
    logic [31:0] Stat_Dual, Stat_Single;
`endif

    dual_issue_unit #(.DEPTH(4), .IW(32)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .In_Valid1(In_Valid1), .In_Valid2(In_Valid2),
        .In_Instr1(In_Instr1), .In_Instr2(In_Instr2),
        .In_Ready(In_Ready), .Iss_Ready(Iss_Ready),
        .Iss_Valid1(Iss_Valid1), .Iss_Valid2(Iss_Valid2),
        .Iss_Instr1(Iss_Instr1), .Iss_Instr2(Iss_Instr2),
        .A11(A11), .A21(A21), .A12(A12), .A22(A22),
        .Iss_Dst1(Iss_Dst1), .Iss_Dst2(Iss_Dst2),
        .Iss_WE1(Iss_WE1), .Iss_WE2(Iss_WE2)
`ifdef ISSUE_STATS_EN
        , .Stat_Dual(Stat_Dual), .Stat_Single(Stat_Single)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] q[$];
    logic        e_v1 = 1'b0, e_v2 = 1'b0;
    logic [31:0] e_i1 = '0, e_i2 = '0;
    int          e_sd = 0, e_ss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] m_op(input logic [31:0] i);
        return i[31:26];
    endfunction

    // A destination of zero means nothing is written
    function automatic logic [4:0] m_dst(input logic [31:0] i);
        case (m_op(i))
            6'd0:                                                  return i[15:11];
            6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35: return i[20:16];
            6'd3:                                                  return 5'd31;
            default:                                               return 5'd0;
        endcase
    endfunction

    function automatic bit m_urt(input logic [31:0] i);
        return m_op(i) inside {6'd0, 6'd43, 6'd4, 6'd5};
    endfunction

    function automatic bit m_pair();
        logic [31:0] a, b;
        if (q.size() < 2) return 0;
        a = q[0];
        b = q[1];
        if (m_op(a) inside {6'd2, 6'd3, 6'd4, 6'd5}) return 0;
        if (m_dst(a) != 0 && (b[25:21] == m_dst(a) || (m_urt(b) && b[20:16] == m_dst(a)))) return 0;
        if (m_dst(a) != 0 && m_dst(a) == m_dst(b)) return 0;
        if ((m_op(a) inside {6'd35, 6'd43}) && (m_op(b) inside {6'd35, 6'd43})) return 0;
        return 1;
    endfunction

    task automatic compare();
        chk("v1", 32'(Iss_Valid1), 32'(e_v1));
        chk("v2", 32'(Iss_Valid2), 32'(e_v2));
        chk("i1", Iss_Instr1, e_i1);
        chk("i2", Iss_Instr2, e_i2);
        chk("a11", 32'(A11), 32'(e_i1[25:21]));
        chk("a21", 32'(A21), 32'(e_i1[20:16]));
        chk("a12", 32'(A12), 32'(e_i2[25:21]));
        chk("a22", 32'(A22), 32'(e_i2[20:16]));
        chk("dst1", 32'(Iss_Dst1), 32'(m_dst(e_i1)));
        chk("dst2", 32'(Iss_Dst2), 32'(m_dst(e_i2)));
        chk("we1", 32'(Iss_WE1), 32'(m_dst(e_i1) != 0));
        chk("we2", 32'(Iss_WE2), 32'(m_dst(e_i2) != 0));
`ifdef ISSUE_STATS_EN
        chk("stat_dual", Stat_Dual, 32'(e_sd));
        chk("stat_single", Stat_Single, 32'(e_ss));
`endif
    endtask

    task automatic step();
        bit rdy;
        rdy = (4 - q.size()) >= 2;
        chk("in_ready", 32'(In_Ready), 32'(rdy));
        if (Flush) begin
            q.delete();
            {e_v1, e_v2, e_i1, e_i2} = '0;
        end else begin
            if (Iss_Ready) begin
                e_v1 = q.size() > 0;
                e_v2 = m_pair();
                e_i1 = e_v1 ? q[0] : '0;
                e_i2 = e_v2 ? q[1] : '0;
                if (e_v2) e_sd++;
                else if (e_v1) e_ss++;
                if (e_v1) void'(q.pop_front());
                if (e_v2) void'(q.pop_front());
            end
            if (In_Valid1 && rdy) begin
                q.push_back(In_Instr1);
                if (In_Valid2) q.push_back(In_Instr2);
            end
        end
        @(posedge Clk);
        #1;
        compare();
    endtask

    task automatic drive(input logic v1, input logic [31:0] i1, input logic v2, input logic [31:0] i2);
        In_Valid1 = v1;
        In_Instr1 = i1;
        In_Valid2 = v2;
        In_Instr2 = i2;
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [5:0] ops [14];
        ops = '{6'd0, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
        return {ops[$urandom_range(13)], 5'($urandom_range(7)), 5'($urandom_range(7)),
                5'($urandom_range(7)), 11'($urandom)};
    endfunction

    initial begin
        #2;
        compare();
        #5 Reset = 1'b1;
        Iss_Ready = 1'b1;

        // independent pair dual-issues one edge after enqueue
        drive(1, 32'h00221820, 1, 32'h00E83020); step();
        drive(0, '0, 0, '0); step();
        chk("ind_v2", 32'(Iss_Valid2), 32'd1);
        chk("ind_a12", 32'(A12), 32'd7);
        chk("ind_dst2", 32'(Iss_Dst2), 32'd6);

        drive(1, 32'h00221820, 1, 32'h00652020); step();
        drive(0, '0, 0, '0); step();
        chk("raw_v2", 32'(Iss_Valid2), 32'd0);
        chk("raw_dst1", 32'(Iss_Dst1), 32'd3);
        step();
        chk("raw_i1", Iss_Instr1, 32'h00652020);
        chk("raw_a11", 32'(A11), 32'd3);

        drive(1, 32'h8D490000, 1, 32'hAD8B0004); step();
        drive(0, '0, 0, '0); step();
        chk("mem_v2", 32'(Iss_Valid2), 32'd0);
        step();

        drive(1, 32'h10220003, 1, 32'h00E83020); step();
        drive(0, '0, 0, '0); step();
        chk("br_we1", 32'(Iss_WE1), 32'd0);
        chk("br_v2", 32'(Iss_Valid2), 32'd0);
        step();
        step();

        // fill with the slot stalled, then drain
        Iss_Ready = 1'b0;
        drive(1, 32'h00221820, 1, 32'h00E83020); step();
        drive(1, 32'h00652020, 1, 32'h8D490000); step();
        chk("full_rdy", 32'(In_Ready), 32'd0);
        drive(1, 32'h10220003, 1, 32'hAD8B0004); step();
        drive(0, '0, 0, '0);
        Iss_Ready = 1'b1;
        repeat (4) step();

        // flush with 3 queued entries and a concurrent push
        Iss_Ready = 1'b0;
        drive(1, 32'h00221820, 1, 32'h00E83020); step();
        drive(1, 32'h00652020, 0, '0); step();
        Flush = 1'b1;
        Iss_Ready = 1'b1;
        drive(1, 32'h8D490000, 1, 32'hAD8B0004); step();
        chk("flush_v1", 32'(Iss_Valid1), 32'd0);
        Flush = 1'b0;
        drive(0, '0, 0, '0);
        step();

        // async reset mid-cycle clears outputs without a clock edge
        drive(1, 32'h00221820, 1, 32'h00E83020); step();
        drive(1, 32'h00652020, 0, '0); step();
        drive(0, '0, 0, '0);
        #3 Reset = 1'b0;
        #1;
        q.delete();
        {e_v1, e_v2, e_i1, e_i2} = '0;
        e_sd = 0;
        e_ss = 0;
        compare();
        #2 Reset = 1'b1;

        for (int n = 0; n < 800; n++) begin
            drive(1'($urandom_range(1)), rnd_ins(), 1'($urandom_range(1)), rnd_ins());
            Iss_Ready = $urandom_range(3) != 0;
            Flush = $urandom_range(39) == 0;
            step();
        end
        Flush = 1'b0;
        drive(0, '0, 0, '0);
        Iss_Ready = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dual_issue_unit.md
Name: dual_issue_unit

Overview:
Front-end issue stage of the dual-issue MIPS core. It sits directly upstream of the 2-write/4-read register file.
- Buffers fetched instruction pairs in a small queue.
- Decodes source and destination fields.
- Checks intra-pair hazards and issues one or two instructions per cycle into a registered issue slot.
- The issue slot drives the register-file read addresses (A11/A21 pipe 1, A12/A22 pipe 2) and the write-back destination tags.

Parameters:
DEPTH, 4, queue entries; power of 2, >=2
IW, 32, instruction width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Flush  in  1  synchronous flush: empties queue and issue slot
In_Valid1  in  1  In_Instr1 valid
In_Valid2  in  1  In_Instr2 valid; only honoured together with In_Valid1
In_Instr1  in  IW  older fetched instruction
In_Instr2  in  IW  younger fetched instruction
In_Ready  out  1  queue has >=2 free entries
Iss_Ready  in  1  downstream accepts the issue slot this cycle
Iss_Valid1, Iss_Valid2  out  1  pipe 1 / pipe 2 slot valid
Iss_Instr1, Iss_Instr2  out  IW  issued instructions
A11, A21  out  5  pipe 1 rs / rt read addresses
A12, A22  out  5  pipe 2 rs / rt read addresses
Iss_Dst1, Iss_Dst2  out  5  write-back destination
Iss_WE1, Iss_WE2  out  1  destination written

Behaviour:
- Reset low (async): queue count=0, rd/wr pointers=0, all Iss_* outputs and A* = 0, In_Ready=1 after release.
- Decode (combinational per entry):
  - rs=[25:21], rt=[20:16].
  - opcode 0: dst=rd[15:11], we=(dst!=0), uses_rt=1.
  - opcodes 8,9,10,12,13,14,15,35: dst=rt, we=(rt!=0), uses_rt=0.
  - 43 (sw), 4, 5: we=0, uses_rt=1.
  - 2, 3: we=0, uses_rt=0; opcode 3 writes $31 (dst=31, we=1).
  - branch/jump = opcodes 2,3,4,5; mem = 35,43.
- Enqueue: when In_Valid1 & In_Ready, Instr1 is written, then Instr2 if In_Valid2. Count += 1 or 2. In_Valid2 without In_Valid1 is ignored.
- In_Ready = (DEPTH - count) >= 2, computed from the registered count; a same-cycle dequeue does not raise it.
- Pairing: head A, next B. Dual issue only if count>=2 and none of:
  - A is branch/jump;
  - RAW: A.we and (B.rs==A.dst or (B.uses_rt and B.rt==A.dst));
  - WAW: A.we and B.we and A.dst==B.dst;
  - A.mem and B.mem.
  - Otherwise A issues alone to pipe 1; Iss_Valid2=0 and pipe 2 fields=0.
- Issue register: loads on each edge with Iss_Ready=1. Dequeue count = number loaded (0, 1, 2).
  - Empty queue with Iss_Ready=1 loads Valid1=Valid2=0.
  - Iss_Ready=0 holds all Iss_*/A* and dequeues nothing.
- Latency: an instruction enqueued at edge N appears on Iss_* at edge N+1 at the earliest (empty queue, Iss_Ready=1).
- Simultaneous enqueue and dequeue: count = count + enq - deq; pointers wrap modulo DEPTH.
- Flush has priority over everything: count=0, pointers=0, issue slot cleared to 0. The same-cycle input is dropped.
- Reset asserted mid-operation discards all state immediately.
- Program order: pipe 1 is always older than pipe 2; a single issue always goes to pipe 1.

Optional Feature:
ISSUE_STATS_EN
- Defined: adds outputs Stat_Dual (32) and Stat_Single (32).
  - Counters increment on each issue-register load with 2 or 1 valid instructions, respectively.
  - Cleared by Reset (not by Flush); wrap at 2^32.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Independent pair: push 0x00221820 (add $3,$1,$2) + 0x00E83020 (add $6,$7,$8), Iss_Ready=1 -> next edge Valid1=Valid2=1, A11=1, A21=2, A12=7, A22=8, Dst1=3, Dst2=6, WE1=WE2=1.
- RAW pair: 0x00221820 + 0x00652020 (add $4,$3,$5) -> first cycle single issue (Dst1=3, Valid2=0); next cycle Instr1=0x00652020, A11=3, A21=5.
- Memory pair and branch head:
  - 0x8D490000 (lw) + 0xAD8B0004 (sw) -> two single issues;
  - 0x10220003 (beq) at head -> single issue, WE1=0.
- Full/stall: Iss_Ready=0, push two pairs -> In_Ready=0 after count=4, third push ignored; Iss_Ready=1 -> drains in program order, In_Ready returns to 1 once count<=2.
- Flush and reset: queue holding 3 entries, Flush=1 with a concurrent push -> next edge count=0, all Iss_Valid=0. Async Reset low mid-cycle -> outputs 0 without a clock edge.
- With ISSUE_STATS_EN: run the first three scenarios -> Stat_Dual=1, Stat_Single=6.
